bpm_meter: RTL

BPM_METER -- requirements
Module: bpm_meter

---
 rtl/bpm_meter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bpm_meter.sv
// bpm_meter: measures the interval between debounced beats and reports BPM as packed BCD.
// Optional macro BPM_AVG_EN divides by the mean of the last four captured intervals.
module bpm_meter #(
  parameter int unsigned CLK_HZ      = 12_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned TIMEOUT_MS  = 3000,
  parameter int unsigned LED_MS      = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat_in,
  output logic [7:0] value,
  output logic       valid,
  output logic       beat_led
);
  localparam int unsigned MsCycles = CLK_HZ / 1000;
  localparam int unsigned DbCycles = DEBOUNCE_MS * MsCycles;
  localparam int unsigned PsW      = (MsCycles > 1) ? $clog2(MsCycles) : 1;
  localparam int unsigned DbW      = $clog2(DbCycles + 1);
  localparam int unsigned LedW     = $clog2(LED_MS + 1);
  localparam logic [15:0] Dividend = 16'd60000;

  typedef enum logic [1:0] {StIdle, StArmed, StDiv, StOut} state_e;
  state_e state_q, state_d;

  logic [1:0]      sync_q;
  logic            deb_q, deb_prev_q;
  logic [DbW-1:0]  db_cnt_q;
  logic [PsW-1:0]  ps_q;
  logic [11:0]     iv_q;
  logic [LedW-1:0] led_cnt_q;
  logic            led_q;
  logic            beat_evt, ms_tick, timeout;
  logic            capture, div_step, emit, abort;
  logic [11:0]     divisor;
  logic [15:0]     dvd_q;
  logic [11:0]     rem_q;
  logic [12:0]     rem_sh;
  logic [3:0]      bit_cnt_q;
  logic [6:0]      q_sat;
  logic [7:0]      value_q;
  logic            valid_q;

  assign beat_evt = deb_q & ~deb_prev_q;
  assign ms_tick  = (ps_q == PsW'(MsCycles - 1));
  assign timeout  = (iv_q == 12'(TIMEOUT_MS));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync_q     <= {sync_q[0], beat_in};
      deb_prev_q <= deb_q;
      if (sync_q[1] == deb_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbW'(DbCycles - 1)) begin
        deb_q    <= sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q      <= '0;
      iv_q      <= '0;
      led_q     <= 1'b0;
      led_cnt_q <= '0;
    end else begin
      ps_q <= ms_tick ? '0 : ps_q + PsW'(1);
      if (beat_evt) iv_q <= '0;
      else if (ms_tick && !timeout) iv_q <= iv_q + 12'd1;
      // Every accepted beat restarts the LED window, even mid-pulse.
      if (beat_evt) begin
        led_q     <= 1'b1;
        led_cnt_q <= '0;
      end else if (led_q && ms_tick) begin
        if (led_cnt_q == LedW'(LED_MS - 1)) led_q <= 1'b0;
        else led_cnt_q <= led_cnt_q + LedW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (beat_evt) state_d = StArmed;
      StArmed: if (timeout) state_d = StIdle; else if (beat_evt) state_d = StDiv;
      StDiv:   if (timeout) state_d = StIdle; else if (bit_cnt_q == 4'd15) state_d = StOut;
      StOut:   state_d = timeout ? StIdle : StArmed;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    div_step = 1'b0;
    emit     = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StArmed: begin abort = timeout; capture  = beat_evt & ~timeout; end
      StDiv:   begin abort = timeout; div_step = ~timeout;            end
      StOut:   begin abort = timeout; emit     = ~timeout;            end
      default: ;
    endcase
  end

`ifdef BPM_AVG_EN
  logic [11:0] hist_q [4];
  logic        first_q;
  logic [13:0] hist_sum;

  assign hist_sum = 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]) + 14'(hist_q[3]);
  assign divisor  = 12'(hist_sum >> 2);

  // The first capture after IDLE fills the whole history so the mean starts settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= 1'b1;
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else begin
      if (state_q == StIdle) first_q <= 1'b1;
      else if (capture) first_q <= 1'b0;
      if (capture) begin
        hist_q[0] <= iv_q;
        hist_q[1] <= first_q ? iv_q : hist_q[0];
        hist_q[2] <= first_q ? iv_q : hist_q[1];
        hist_q[3] <= first_q ? iv_q : hist_q[2];
      end
    end
  end
`else
  logic [11:0] iv_lat_q;

  assign divisor = iv_lat_q;

  always_ff @(posedge clk) begin
    if (rst) iv_lat_q <= '0;
    else if (capture) iv_lat_q <= iv_q;
  end
`endif

  // Restoring divider: dvd_q shifts the dividend out and the quotient in.
  assign rem_sh = {rem_q, dvd_q[15]};

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q     <= '0;
      rem_q     <= '0;
      bit_cnt_q <= '0;
    end else if (capture) begin
      dvd_q     <= Dividend;
      rem_q     <= '0;
      bit_cnt_q <= '0;
    end else if (div_step) begin
      bit_cnt_q <= bit_cnt_q + 4'd1;
      if (rem_sh >= {1'b0, divisor}) begin
        rem_q <= 12'(rem_sh - {1'b0, divisor});
        dvd_q <= {dvd_q[14:0], 1'b1};
      end else begin
        rem_q <= rem_sh[11:0];
        dvd_q <= {dvd_q[14:0], 1'b0};
      end
    end
  end

  assign q_sat = (divisor == 12'd0 || dvd_q > 16'd99) ? 7'd99 : dvd_q[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      valid_q <= emit | abort;
      if (abort) value_q <= 8'h00;
      else if (emit) value_q <= {4'(q_sat / 7'd10), 4'(q_sat % 7'd10)};
    end
  end

  assign value    = value_q;
  assign valid    = valid_q;
  assign beat_led = led_q;
endmodule
